// File: rtl/controlador_sincronia_vga_pkg.sv
// vga_timing_defs: 640x480@60 timing constants, grant FSM encodings and window decode helper.
package vga_timing_defs;
  localparam int CLK_DIV      = 4;
  localparam int H_ACT_START  = 48;
  localparam int H_ACT        = 640;
  localparam int H_SYNC_START = 704;
  localparam int H_SYNC_LEN   = 96;
  localparam int H_TOTAL      = 800;
  localparam int V_ACT_START  = 30;
  localparam int V_ACT        = 480;
  localparam int V_SYNC_START = 520;
  localparam int V_SYNC_LEN   = 2;
  localparam int V_TOTAL      = 525;
  localparam int GUARD_LINES  = 2;
  localparam logic [1:0] G_IDLE      = 2'd0;
  localparam logic [1:0] G_GRANT     = 2'd1;
  localparam logic [1:0] G_WAIT_DROP = 2'd2;
  function automatic logic in_win(input logic [9:0] v, input int lo, input int len);
    return int'(v) >= lo && int'(v) < lo + len;
  endfunction
endpackage

// File: rtl/controlador_sincronia_vga_contador_modulo.sv
// contador_modulo: W-bit modulo-M counter with enable, sync clear, next-value and carry-out.
module contador_modulo #(
  parameter int W = 10,
  parameter int M = 800
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt,
  output logic         co
);
  localparam logic [W-1:0] LAST = W'(M - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    co = en && cnt_q == LAST;
    cnt_d = clr ? '0 : co ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign q = cnt_q;
  assign nxt = cnt_d;
endmodule

// File: rtl/controlador_sincronia_vga.sv
// controlador_sincronia_vga: VGA timing sequencer with vblank-only display-RAM update arbitration.
module controlador_sincronia_vga import vga_timing_defs::*; #(
  parameter int CLK_DIV      = vga_timing_defs::CLK_DIV,
  parameter int H_ACT_START  = vga_timing_defs::H_ACT_START,
  parameter int H_ACT        = vga_timing_defs::H_ACT,
  parameter int H_SYNC_START = vga_timing_defs::H_SYNC_START,
  parameter int H_SYNC_LEN   = vga_timing_defs::H_SYNC_LEN,
  parameter int H_TOTAL      = vga_timing_defs::H_TOTAL,
  parameter int V_ACT_START  = vga_timing_defs::V_ACT_START,
  parameter int V_ACT        = vga_timing_defs::V_ACT,
  parameter int V_SYNC_START = vga_timing_defs::V_SYNC_START,
  parameter int V_SYNC_LEN   = vga_timing_defs::V_SYNC_LEN,
  parameter int V_TOTAL      = vga_timing_defs::V_TOTAL,
  parameter int GUARD_LINES  = vga_timing_defs::GUARD_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic       hsync,
  output logic       vsync,
  output logic       Blank,
  output logic       pixel_tick,
  output logic       frame_start,
  input  logic       upd_req,
  output logic       upd_grant
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [9:0] REVOKE_Y = 10'(V_ACT_START - GUARD_LINES);
  logic [DW-1:0] div_q, div_d;
  logic [9:0] x_d, y_d;
  logic x_wrap, y_wrap, vb;
  logic hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, fs_q, fs_d;
  logic [1:0] g_q, g_d;
  logic unused_div;
  assign unused_div = ^{div_q, div_d};
  contador_modulo #(.W(DW), .M(CLK_DIV)) u_div (
    .clk(clk), .reset(reset), .en(enable), .clr(!enable), .q(div_q), .nxt(div_d), .co(pixel_tick)
  );
  contador_modulo #(.W(10), .M(H_TOTAL)) u_x (
    .clk(clk), .reset(reset), .en(pixel_tick), .clr(!enable), .q(PosX), .nxt(x_d), .co(x_wrap)
  );
  contador_modulo #(.W(10), .M(V_TOTAL)) u_y (
    .clk(clk), .reset(reset), .en(x_wrap), .clr(!enable), .q(PosY), .nxt(y_d), .co(y_wrap)
  );
  // Decoding the next-state counters keeps sync/blank aligned with PosX/PosY.
  always_comb begin
    hsync_d = !(enable && in_win(x_d, H_SYNC_START, H_SYNC_LEN));
    vsync_d = !(enable && in_win(y_d, V_SYNC_START, V_SYNC_LEN));
    blank_d = !(enable && in_win(x_d, H_ACT_START, H_ACT) && in_win(y_d, V_ACT_START, V_ACT));
    fs_d = x_wrap && y_wrap;
    vb = int'(PosY) >= V_ACT_START + V_ACT || int'(PosY) < V_ACT_START - GUARD_LINES;
    g_d = !enable ? G_IDLE :
          g_q == G_IDLE ? (upd_req && vb ? G_GRANT : G_IDLE) :
          g_q == G_GRANT ? (PosY == REVOKE_Y ? G_WAIT_DROP : !upd_req ? G_IDLE : G_GRANT) :
          (!upd_req ? G_IDLE : G_WAIT_DROP);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b1;
      fs_q <= 1'b0;
      g_q <= G_IDLE;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      fs_q <= fs_d;
      g_q <= g_d;
    end
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign Blank = blank_q;
  assign frame_start = fs_q;
  assign upd_grant = g_q == G_GRANT;
endmodule

// File: tb/tb_controlador_sincronia_vga.sv
// tb_controlador_sincronia_vga: directed vectors on a full-width-line instance and a full-height-frame instance.
module tb_controlador_sincronia_vga;
  typedef struct {
    int f, x, y, s, bl, hs, vs, fs, tk;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, req_a = 1'b0, req_b = 1'b0;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic hs_a, vs_a, bl_a, tk_a, fs_a, g_a;
  logic hs_b, vs_b, bl_b, tk_b, fs_b, g_b;
  int total = 0, bad = 0, n = 0;
  vec_t ta[18], tv[16];
  always #5 clk = ~clk;
  controlador_sincronia_vga #(
    .V_ACT_START(3), .V_ACT(4), .V_SYNC_START(8), .V_SYNC_LEN(2), .V_TOTAL(10), .GUARD_LINES(1)
  ) u_a (
    .clk(clk), .reset(reset), .enable(en_a), .PosX(x_a), .PosY(y_a), .hsync(hs_a), .vsync(vs_a),
    .Blank(bl_a), .pixel_tick(tk_a), .frame_start(fs_a), .upd_req(req_a), .upd_grant(g_a)
  );
  controlador_sincronia_vga #(
    .CLK_DIV(2), .H_ACT_START(2), .H_ACT(4), .H_SYNC_START(7), .H_SYNC_LEN(2), .H_TOTAL(10)
  ) u_b (
    .clk(clk), .reset(reset), .enable(en_b), .PosX(x_b), .PosY(y_b), .hsync(hs_b), .vsync(vs_b),
    .Blank(bl_b), .pixel_tick(tk_b), .frame_start(fs_b), .upd_req(req_b), .upd_grant(g_b)
  );
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step_to(input int t);
    if (t > n) repeat (t - n) @(negedge clk);
    n = t;
  endtask
  function automatic int tb_t(input int f, input int x, input int y, input int s);
    return 2 * ((f * 525 + y) * 10 + x) + s;
  endfunction
  task automatic chk_idle_b(input string p);
    chk({p, ".PosX"}, int'(x_b), 0);
    chk({p, ".PosY"}, int'(y_b), 0);
    chk({p, ".hsync"}, int'(hs_b), 1);
    chk({p, ".vsync"}, int'(vs_b), 1);
    chk({p, ".Blank"}, int'(bl_b), 1);
    chk({p, ".tick"}, int'(tk_b), 0);
    chk({p, ".fs"}, int'(fs_b), 0);
    chk({p, ".grant"}, int'(g_b), 0);
  endtask
  initial begin
    ta = '{
      '{0,   0, 0, 1, 1, 1, 1, 0, 0}, '{0, 703, 0, 3, 1, 1, 1, 0, 1},
      '{0, 704, 0, 0, 1, 0, 1, 0, 0}, '{0, 799, 0, 3, 1, 0, 1, 0, 1},
      '{0,   0, 1, 0, 1, 1, 1, 0, 0}, '{0,  48, 2, 0, 1, 1, 1, 0, 0},
      '{0,  47, 3, 3, 1, 1, 1, 0, 1}, '{0,  48, 3, 0, 0, 1, 1, 0, 0},
      '{0, 687, 3, 3, 0, 1, 1, 0, 1}, '{0, 688, 3, 0, 1, 1, 1, 0, 0},
      '{0, 687, 6, 0, 0, 1, 1, 0, 0}, '{0,  48, 7, 0, 1, 1, 1, 0, 0},
      '{0, 799, 7, 3, 1, 0, 1, 0, 1}, '{0,   0, 8, 0, 1, 1, 0, 0, 0},
      '{0, 704, 9, 0, 1, 0, 0, 0, 0}, '{0, 799, 9, 3, 1, 0, 0, 0, 1},
      '{1,   0, 0, 0, 1, 1, 1, 1, 0}, '{1,   0, 0, 1, 1, 1, 1, 0, 0}
    };
    tv = '{
      '{0, 0,   0, 1, 1, 1, 1, 0, 1}, '{0, 5,  29, 0, 1, 1, 1, 0, 0},
      '{0, 1,  30, 1, 1, 1, 1, 0, 1}, '{0, 2,  30, 0, 0, 1, 1, 0, 0},
      '{0, 5,  30, 1, 0, 1, 1, 0, 1}, '{0, 6,  30, 0, 1, 1, 1, 0, 0},
      '{0, 7,  30, 0, 1, 0, 1, 0, 0}, '{0, 5, 509, 1, 0, 1, 1, 0, 1},
      '{0, 2, 510, 0, 1, 1, 1, 0, 0}, '{0, 9, 519, 1, 1, 1, 1, 0, 1},
      '{0, 0, 520, 0, 1, 1, 0, 0, 0}, '{0, 9, 521, 1, 1, 1, 0, 0, 1},
      '{0, 0, 522, 0, 1, 1, 1, 0, 0}, '{0, 9, 524, 1, 1, 1, 1, 0, 1},
      '{1, 0,   0, 0, 1, 1, 1, 1, 0}, '{1, 0,   0, 1, 1, 1, 1, 0, 1}
    };
    repeat (3) @(negedge clk);
    chk_idle_b("rst0");
    chk("rst0.A.hsync", int'(hs_a), 1);
    chk("rst0.A.Blank", int'(bl_a), 1);
    reset = 1'b1;
    @(negedge clk);
    en_a = 1'b1;
    n = 0;
    foreach (ta[i]) begin
      step_to(4 * ((ta[i].f * 10 + ta[i].y) * 800 + ta[i].x) + ta[i].s);
      chk($sformatf("A[%0d].PosX", i), int'(x_a), ta[i].x);
      chk($sformatf("A[%0d].PosY", i), int'(y_a), ta[i].y);
      chk($sformatf("A[%0d].Blank", i), int'(bl_a), ta[i].bl);
      chk($sformatf("A[%0d].hsync", i), int'(hs_a), ta[i].hs);
      chk($sformatf("A[%0d].vsync", i), int'(vs_a), ta[i].vs);
      chk($sformatf("A[%0d].fs", i), int'(fs_a), ta[i].fs);
      chk($sformatf("A[%0d].tick", i), int'(tk_a), ta[i].tk);
    end
    en_a = 1'b0;
    @(negedge clk);
    chk("A.off.PosX", int'(x_a), 0);
    en_b = 1'b1;
    n = 0;
    foreach (tv[i]) begin
      step_to(tb_t(tv[i].f, tv[i].x, tv[i].y, tv[i].s));
      chk($sformatf("B[%0d].PosX", i), int'(x_b), tv[i].x);
      chk($sformatf("B[%0d].PosY", i), int'(y_b), tv[i].y);
      chk($sformatf("B[%0d].Blank", i), int'(bl_b), tv[i].bl);
      chk($sformatf("B[%0d].hsync", i), int'(hs_b), tv[i].hs);
      chk($sformatf("B[%0d].vsync", i), int'(vs_b), tv[i].vs);
      chk($sformatf("B[%0d].fs", i), int'(fs_b), tv[i].fs);
      chk($sformatf("B[%0d].tick", i), int'(tk_b), tv[i].tk);
    end
    en_b = 1'b0;
    @(negedge clk);
    en_b = 1'b1;
    n = 0;
    step_to(tb_t(0, 0, 100, 0));
    req_b = 1'b1;
    step_to(tb_t(0, 9, 509, 1));
    chk("grant_in_active", int'(g_b), 0);
    step_to(tb_t(0, 0, 510, 0));
    chk("grant_y510_first", int'(g_b), 0);
    step_to(tb_t(0, 0, 510, 1));
    chk("grant_rise", int'(g_b), 1);
    step_to(tb_t(0, 0, 511, 0));
    req_b = 1'b0;
    step_to(n + 1);
    chk("grant_fall", int'(g_b), 0);
    step_to(tb_t(0, 0, 512, 0));
    req_b = 1'b1;
    step_to(n + 1);
    chk("grant_again", int'(g_b), 1);
    step_to(tb_t(1, 5, 5, 0));
    chk("grant_over_wrap", int'(g_b), 1);
    step_to(tb_t(1, 9, 27, 1));
    chk("grant_y27", int'(g_b), 1);
    step_to(tb_t(1, 0, 28, 1));
    chk("grant_revoked", int'(g_b), 0);
    step_to(tb_t(1, 0, 100, 0));
    chk("revoked_active", int'(g_b), 0);
    step_to(tb_t(1, 0, 515, 0));
    chk("no_regrant_held", int'(g_b), 0);
    req_b = 1'b0;
    step_to(n + 1);
    chk("req_low_515", int'(g_b), 0);
    req_b = 1'b1;
    step_to(n + 1);
    chk("regrant_515", int'(g_b), 1);
    en_b = 1'b0;
    step_to(n + 1);
    chk_idle_b("en_off");
    en_b = 1'b1;
    n = 0;
    step_to(tb_t(0, 3, 200, 0));
    chk("pre_rst.PosX", int'(x_b), 3);
    chk("pre_rst.PosY", int'(y_b), 200);
    #2 reset = 1'b0;
    #1 chk_idle_b("async_rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_release.fs", int'(fs_b), 0);
    chk("rst_release.PosX", int'(x_b), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
